baseerat_update_scheduler: RTL and testbench
============================================

BASEERAT_UPDATE_SCHEDULER -- requirements
Module: baseerat_update_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 256, SHALL set the width of req_data and udin.
REQ-002 Parameter PIPELINE_STAGES, default 32, SHALL set the width of update, equal to the downstream shift register stage count.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two >= 2, SHALL set the request buffer depth.
REQ-004 Derived constant STAGE_W = clog2(PIPELINE_STAGES) SHALL set the width of req_stage.
REQ-005 clock  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_stage  input  STAGE_W  target stage index.
REQ-009 req_data  input  DATA_WIDTH  value to inject.
REQ-010 req_ready  output  1  request accepted when valid and ready are both high at an edge.
REQ-011 hold  input  1  suppresses issue while high.
REQ-012 update  output  PIPELINE_STAGES  one-hot or zero stage-select to the shift register.
REQ-013 udin  output  DATA_WIDTH  injection data to the shift register.
REQ-014 err_drop  output  1  one-cycle pulse when an out-of-range request is discarded.
REQ-015 fifo_count  output  clog2(FIFO_DEPTH)+1  current buffer occupancy.

Function
REQ-016 An accepted request with req_stage < PIPELINE_STAGES SHALL be written to the FIFO.
REQ-017 An accepted request with req_stage >= PIPELINE_STAGES SHALL NOT be written to the FIFO, and err_drop SHALL be high in the following cycle.
REQ-018 req_ready SHALL equal (fifo_count != FIFO_DEPTH), derived from registered state only, with no combinational path from hold or from a pop in the same cycle.
REQ-019 The FSM SHALL have three states: IDLE (FIFO empty), ISSUE (FIFO non-empty and hold low) and STALL (FIFO non-empty and hold high).
REQ-020 FSM transitions SHALL be re-evaluated at every edge from the next-cycle occupancy and the current hold value.
REQ-021 In ISSUE, exactly one entry SHALL be popped per cycle.
REQ-022 On the edge following a pop, update SHALL become one-hot at bit head.stage and udin SHALL equal head.data, both registered.
REQ-023 Latency SHALL be two edges from request acceptance into an empty FIFO to the edge at which update/udin become visible, with hold low.
REQ-024 In any cycle in which no pop occurs, update SHALL be all zero and udin SHALL hold its last value.
REQ-025 At most one bit of update SHALL be set in any cycle.
REQ-026 Simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-027 Entries SHALL issue in FIFO order.
REQ-028 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 Asserting hold SHALL zero update on the next edge, with no entry lost.
REQ-030 While hold is high, pushes SHALL continue until the FIFO is full.

Reset
REQ-031 While reset is high, update SHALL be 0, udin SHALL be 0, err_drop SHALL be 0 and fifo_count SHALL be 0.
REQ-032 While reset is high, req_ready SHALL be 1, the FSM SHALL be in IDLE and both FIFO pointers SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-034 No request SHALL be accepted on an edge at which reset is high.

Structure
REQ-035 The FSM state encoding and the STAGE_W derivation SHALL reside in the shared package baseerat_pkg.
REQ-036 The request buffer SHALL be a sub-module, baseerat_sync_fifo, parameterised by width (STAGE_W+DATA_WIDTH) and depth.
REQ-037 The FIFO storage SHALL NOT require reset; only pointers and occupancy SHALL be reset.

Verification
REQ-038 Reset release, then one request {stage=5, data=0xA5} with hold=0 -> update=0x0000_0020 and udin=0xA5 two edges after acceptance, then update=0.
REQ-039 Push 4 requests back-to-back with hold=1 -> fifo_count=4 and req_ready=0; deassert hold -> stages issue in order on 4 consecutive cycles and req_ready returns to 1.
REQ-040 Request with stage=32 (PIPELINE_STAGES=32) -> err_drop pulses for one cycle, fifo_count stays 0 and update never asserts.
REQ-041 Continuous push with hold=0 for 10 cycles -> fifo_count stays at 1, exactly one update per cycle, and pointers wrap without loss.
REQ-042 Assert reset with 3 entries buffered -> update=0, fifo_count=0 and req_ready=1 immediately; no stale entry issues after reset release.
REQ-043 Toggle hold on alternating cycles with 3 entries buffered -> updates occur only in the cycle after hold=0, and all 3 entries issue in order.

Source files
------------

// File: rtl/baseerat_pkg.sv
// Shared definitions for the BaseErat update scheduler.
//   sched_state_e : issue FSM state encoding
//   stage_w()     : width of a stage index for a given shift-register length
//   count_w()     : width of an occupancy counter for a given buffer depth
package baseerat_pkg;

  // IDLE  : request buffer empty
  // ISSUE : buffer non-empty, hold low  -> one entry leaves per cycle
  // STALL : buffer non-empty, hold high -> entries wait
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_STALL = 2'd2
  } sched_state_e;

  // A single-stage register still needs a one-bit index.
  function automatic int stage_w(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

  // Occupancy runs 0..depth inclusive, hence the extra bit.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/baseerat_update_scheduler_if.sv
// Request / update bus of the BaseErat update scheduler.
//   req_valid, req_stage, req_data : request from the producer
//   req_ready                      : buffer has room (registered)
//   hold                           : stall issue towards the shift register
//   update, udin                   : one-hot stage select and injection data
//   err_drop                       : pulse when an out-of-range request is dropped
//   fifo_count                     : current buffer occupancy
// master = producer / shift-register side, slave = scheduler.
interface baseerat_update_scheduler_if
  import baseerat_pkg::*;
#(
  parameter int DATA_WIDTH      = 256,
  parameter int PIPELINE_STAGES = 32,
  parameter int FIFO_DEPTH      = 4
);
  localparam int STAGE_W = stage_w(PIPELINE_STAGES);
  localparam int CNT_W   = count_w(FIFO_DEPTH);

  logic                       req_valid;
  logic [STAGE_W-1:0]         req_stage;
  logic [DATA_WIDTH-1:0]      req_data;
  logic                       req_ready;
  logic                       hold;
  logic [PIPELINE_STAGES-1:0] update;
  logic [DATA_WIDTH-1:0]      udin;
  logic                       err_drop;
  logic [CNT_W-1:0]           fifo_count;

  modport master (
    output req_valid, req_stage, req_data, hold,
    input  req_ready, update, udin, err_drop, fifo_count
  );

  modport slave (
    input  req_valid, req_stage, req_data, hold,
    output req_ready, update, udin, err_drop, fifo_count
  );
endinterface

// File: rtl/baseerat_sync_fifo.sv
// Single-clock request buffer, first-word fall-through read.
//   clock, reset : clock and asynchronous active-high reset
//   push, wdata  : write one entry (caller guarantees not full)
//   pop          : retire the head entry (caller guarantees not empty)
//   rdata        : current head entry
//   count        : occupancy, 0..DEPTH
//   full         : count == DEPTH
module baseerat_sync_fifo
  import baseerat_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  // NOTE: storage carries no reset; an entry is only ever read after it was
  // written, so only pointers and occupancy need a defined reset value.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      // DEPTH is a power of two, so natural overflow is the modulo wrap.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/baseerat_update_scheduler.sv
// Buffers stage-update requests and issues them one per cycle to a
// PIPELINE_STAGES-deep shift register as a one-hot select plus data.
//   clock, reset : clock and asynchronous active-high reset
//   bus          : request / update interface (slave side)
// Requests aimed past the last stage are discarded and flagged on err_drop.
// req_ready depends on registered occupancy only.
module baseerat_update_scheduler
  import baseerat_pkg::*;
#(
  parameter int DATA_WIDTH      = 256,
  parameter int PIPELINE_STAGES = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  baseerat_update_scheduler_if.slave   bus
);
  localparam int STAGE_W = stage_w(PIPELINE_STAGES);
  localparam int CNT_W   = count_w(FIFO_DEPTH);
  localparam int ENTRY_W = STAGE_W + DATA_WIDTH;

  sched_state_e          state;
  logic                  full;
  logic                  accept;
  logic                  in_range;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      next_count;
  logic [ENTRY_W-1:0]    head;
  logic [STAGE_W-1:0]    head_stage;
  logic [DATA_WIDTH-1:0] head_data;

  assign bus.req_ready  = !full;
  assign bus.fifo_count = count;

  assign accept   = bus.req_valid && !full;
  assign in_range = int'(bus.req_stage) < PIPELINE_STAGES;
  assign push     = accept && in_range;

  // A non-IDLE state guarantees a buffered entry. Current hold gates the pop
  // so that raising hold silences update on the very next edge.
  assign pop = (state != S_IDLE) && !bus.hold;

  assign {head_stage, head_data} = head;

  baseerat_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata ({bus.req_stage, bus.req_data}),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full)
  );

  // NOTE: next_count is assigned on every path (default first) so no latch
  // is inferred.
  always_comb begin
    next_count = count;
    case ({push, pop})
      2'b10:   next_count = count + 1'b1;
      2'b01:   next_count = count - 1'b1;
      default: next_count = count;
    endcase
  end

  // Issue FSM with registered outputs. The state for the coming cycle is
  // chosen from the post-edge occupancy and the hold value seen now.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      bus.update   <= '0;
      bus.udin     <= '0;
      bus.err_drop <= 1'b0;
    end else begin
      bus.err_drop <= accept && !in_range;

      bus.update <= '0;
      if (pop) begin
        bus.update <= PIPELINE_STAGES'(1) << head_stage;
        bus.udin   <= head_data;
      end

      if (next_count == '0)  state <= S_IDLE;
      else if (bus.hold)     state <= S_STALL;
      else                   state <= S_ISSUE;
    end
  end

endmodule

// File: tb/tb_baseerat_update_scheduler.sv
// Self-checking bench for baseerat_update_scheduler.
// Main instance uses default parameters; a second, shorter instance
// (20 stages) makes out-of-range stage indices representable.
module tb_baseerat_update_scheduler;
  localparam int DW   = 256;
  localparam int PS   = 32;
  localparam int FD   = 4;
  localparam int SW   = 5;
  localparam int E_DW = 8;
  localparam int E_PS = 20;
  localparam int E_FD = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  baseerat_update_scheduler_if #(.DATA_WIDTH(DW), .PIPELINE_STAGES(PS), .FIFO_DEPTH(FD)) bus ();
  baseerat_update_scheduler_if #(.DATA_WIDTH(E_DW), .PIPELINE_STAGES(E_PS), .FIFO_DEPTH(E_FD)) e_bus ();

  baseerat_update_scheduler #(.DATA_WIDTH(DW), .PIPELINE_STAGES(PS), .FIFO_DEPTH(FD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  baseerat_update_scheduler #(.DATA_WIDTH(E_DW), .PIPELINE_STAGES(E_PS), .FIFO_DEPTH(E_FD)) dut_e (
    .clock (clock),
    .reset (reset),
    .bus   (e_bus)
  );

  typedef struct packed {
    logic [SW-1:0] stage;
    logic [DW-1:0] data;
  } entry_t;

  entry_t exp_q[$];
  entry_t mon_e;
  int n_tests   = 0;
  int n_fail    = 0;
  int n_updates = 0;
  int e_updates = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one request for one edge; the expected issue is queued.
  task automatic send(input logic [SW-1:0] stage, input logic [DW-1:0] data);
    bus.req_valid = 1'b1;
    bus.req_stage = stage;
    bus.req_data  = data;
    exp_q.push_back('{stage: stage, data: data});
    tick();
  endtask

  task automatic e_send(input logic [SW-1:0] stage, input logic [E_DW-1:0] data);
    e_bus.req_valid = 1'b1;
    e_bus.req_stage = stage;
    e_bus.req_data  = data;
    tick();
    e_bus.req_valid = 1'b0;
  endtask

  // Monitor: every non-zero update must match the oldest outstanding request.
  always @(negedge clock) begin
    if (!reset && bus.update != '0) begin
      n_updates++;
      check("update_onehot", DW'($onehot(bus.update)), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_update", DW'(bus.update), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("update_stage", DW'(bus.update), DW'(32'(1) << mon_e.stage));
        check("update_udin", bus.udin, mon_e.data);
      end
    end
    if (!reset && e_bus.update != '0) e_updates++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int remaining;
    bit exp_fire;
    logic h;
    logic [SW-1:0] t2_stage [4];
    logic [DW-1:0] last_data;
    t2_stage[0] = 5'd0;
    t2_stage[1] = 5'd31;
    t2_stage[2] = 5'd7;
    t2_stage[3] = 5'd16;

    bus.req_valid   = 1'b0;
    bus.req_stage   = '0;
    bus.req_data    = '0;
    bus.hold        = 1'b0;
    e_bus.req_valid = 1'b0;
    e_bus.req_stage = '0;
    e_bus.req_data  = '0;
    e_bus.hold      = 1'b0;

    // Reset state
    #1;
    check("rst_update", DW'(bus.update), 0);
    check("rst_udin", bus.udin, 0);
    check("rst_err", DW'(bus.err_drop), 0);
    check("rst_count", DW'(bus.fifo_count), 0);
    check("rst_ready", DW'(bus.req_ready), 1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Single request: visible on the second edge counting the accepting one
    send(5'd5, DW'(8'hA5));
    bus.req_valid = 1'b0;
    check("t1_count_accept", DW'(bus.fifo_count), 1);
    check("t1_update_early", DW'(bus.update), 0);
    tick();
    check("t1_update", DW'(bus.update), DW'(32'h0000_0020));
    check("t1_udin", bus.udin, DW'(8'hA5));
    check("t1_count_drain", DW'(bus.fifo_count), 0);
    tick();
    check("t1_update_clear", DW'(bus.update), 0);
    check("t1_udin_hold", bus.udin, DW'(8'hA5));

    // Fill under hold, then drain in order
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) send(t2_stage[i], {8{32'hC0DE_0000 + 32'(i)}});
    bus.req_valid = 1'b0;
    check("t2_count_full", DW'(bus.fifo_count), 4);
    check("t2_ready_full", DW'(bus.req_ready), 0);
    tick();
    check("t2_hold_quiet", DW'(bus.update), 0);
    check("t2_count_held", DW'(bus.fifo_count), 4);
    bus.hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t2_issue", DW'(bus.update != '0), 1);
      check("t2_count", DW'(bus.fifo_count), DW'(4 - k));
      check("t2_ready", DW'(bus.req_ready), 1);
    end
    tick();
    check("t2_done", DW'(bus.update), 0);

    // Continuous stream: occupancy stays at one, pointers wrap
    last_data = '0;
    for (int i = 0; i < 10; i++) begin
      last_data = {4{64'hF00D_0000_0000_0000 + 64'(i * 17)}};
      send(SW'((i * 7 + 3) % 32), last_data);
      check("t3_count", DW'(bus.fifo_count), 1);
      if (i > 0) check("t3_issue", DW'(bus.update != '0), 1);
    end
    bus.req_valid = 1'b0;
    tick();
    check("t3_count_end", DW'(bus.fifo_count), 0);
    check("t3_last_issue", DW'(bus.update != '0), 1);
    tick();
    check("t3_quiet", DW'(bus.update), 0);
    check("t3_udin_hold", bus.udin, last_data);

    // Asynchronous reset with entries buffered and an update in flight
    bus.hold = 1'b1;
    send(5'd2,  DW'(32'h1111_2222));
    send(5'd12, DW'(32'h3333_4444));
    send(5'd30, DW'(32'h5555_6666));
    bus.req_valid = 1'b0;
    bus.hold = 1'b0;
    tick();
    check("t4_pre_update", DW'(bus.update != '0), 1);
    #5;
    reset = 1'b1;
    #1;
    check("t4_update", DW'(bus.update), 0);
    check("t4_count", DW'(bus.fifo_count), 0);
    check("t4_ready", DW'(bus.req_ready), 1);
    check("t4_udin", bus.udin, 0);
    exp_q.delete();
    bus.req_valid = 1'b1;
    bus.req_stage = 5'd4;
    bus.req_data  = DW'(32'hBAD0_BAD0);
    tick();
    bus.req_valid = 1'b0;
    reset = 1'b0;
    check("t4_no_accept", DW'(bus.fifo_count), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_no_stale", DW'(bus.update), 0);
      check("t4_count_post", DW'(bus.fifo_count), 0);
    end

    // Alternating hold: issue only after a hold-low cycle
    bus.hold = 1'b1;
    send(5'd3,  DW'(32'hAAAA_0003));
    send(5'd9,  DW'(32'hAAAA_0009));
    send(5'd27, DW'(32'hAAAA_001B));
    bus.req_valid = 1'b0;
    remaining = 3;
    for (int c = 0; c < 8; c++) begin
      bus.hold = (c % 2 == 0) ? 1'b0 : 1'b1;
      h = bus.hold;
      tick();
      exp_fire = (h == 1'b0) && (remaining > 0);
      check("t5_fire", DW'(bus.update != '0), DW'(exp_fire));
      if (exp_fire) remaining--;
    end
    check("t5_count", DW'(bus.fifo_count), 0);
    bus.hold = 1'b0;

    // Out-of-range drops on the 20-stage instance
    e_send(5'd25, 8'h11);
    check("t6_err_25", DW'(e_bus.err_drop), 1);
    check("t6_count_25", DW'(e_bus.fifo_count), 0);
    tick();
    check("t6_err_pulse", DW'(e_bus.err_drop), 0);
    check("t6_no_update", DW'(e_bus.update), 0);
    e_send(5'd20, 8'h22);
    check("t6_err_20", DW'(e_bus.err_drop), 1);
    check("t6_count_20", DW'(e_bus.fifo_count), 0);
    e_send(5'd19, 8'h5C);
    check("t6_err_19", DW'(e_bus.err_drop), 0);
    check("t6_count_19", DW'(e_bus.fifo_count), 1);
    tick();
    check("t6_update_19", DW'(e_bus.update), DW'(20'h80000));
    check("t6_udin_19", DW'(e_bus.udin), DW'(8'h5C));
    tick();
    check("t6_quiet", DW'(e_bus.update), 0);

    repeat (3) tick();
    check("queue_drained", DW'(exp_q.size()), 0);
    check("main_updates", DW'(n_updates), 19);
    check("e_updates", DW'(e_updates), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
